// File: rtl/gemm_desc_issuer_if.sv
// Descriptor handshake and system-bus signals for gemm_desc_issuer.
// master = issuer side, slave = command source / bus target side.
interface gemm_desc_issuer_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  logic          desc_valid;
  logic          desc_ready;
  logic [DW-1:0] desc_a_addr;
  logic [DW-1:0] desc_b_addr;
  logic [DW-1:0] desc_c_addr;
  logic [DW-1:0] desc_a_stride;
  logic [DW-1:0] desc_b_stride;
  logic [SW-1:0] desc_msize;
  logic [SW-1:0] desc_ksize;
  logic [SW-1:0] desc_nsize;
  logic          desc_store;
  logic          desc_overwrite;

  logic          system_bus_en;
  logic          system_bus_rdwr;
  logic [AW-1:0] system_bus_addr;
  logic [DW-1:0] system_bus_wr_data;
  logic [DW-1:0] system_bus_rd_data;

  modport master (
    input  desc_valid, desc_a_addr, desc_b_addr, desc_c_addr,
           desc_a_stride, desc_b_stride, desc_msize, desc_ksize, desc_nsize,
           desc_store, desc_overwrite, system_bus_rd_data,
    output desc_ready, system_bus_en, system_bus_rdwr, system_bus_addr,
           system_bus_wr_data
  );

  modport slave (
    output desc_valid, desc_a_addr, desc_b_addr, desc_c_addr,
           desc_a_stride, desc_b_stride, desc_msize, desc_ksize, desc_nsize,
           desc_store, desc_overwrite, system_bus_rd_data,
    input  desc_ready, system_bus_en, system_bus_rdwr, system_bus_addr,
           system_bus_wr_data
  );
endinterface

// File: rtl/gemm_desc_issuer.sv
// Issues GEMM tile descriptors as seven bus writes after polling the config FIFO full flag.
// Optional poll timeout enabled by defining GEMM_ISSUER_TIMEOUT_EN.
module gemm_desc_issuer #(
  parameter logic [31:0] BASE_ADDR      = 32'h9000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  gemm_desc_issuer_if.master  bus,
  output logic                busy,
  output logic [15:0]         issued_count,
  output logic                err_timeout
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned CW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5, S_WR6
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [DW-1:0] a_stride_q, a_stride_d, b_stride_q, b_stride_d;
  logic [SW-1:0] msize_q, msize_d, ksize_q, ksize_d, nsize_q, nsize_d;
  logic          store_q, store_d, overwrite_q, overwrite_d;

  logic          accept;
  logic          fifo_full;
  logic          timeout_hit;
  logic [CW-1:0] issued_q, issued_d;

  logic          en_q, en_d, rdwr_q, rdwr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ready_q, ready_d, busy_q, busy_d, err_q, err_d;

  logic [DW-2:0] unused_rd_bits;

  assign accept         = (state_q == S_IDLE) && bus.desc_valid;
  assign fifo_full      = bus.system_bus_rd_data[0];
  assign unused_rd_bits = bus.system_bus_rd_data[DW-1:1];

  // Descriptor capture; fields are frozen from acceptance until the next IDLE.
  always_comb begin
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    c_addr_d    = c_addr_q;
    a_stride_d  = a_stride_q;
    b_stride_d  = b_stride_q;
    msize_d     = msize_q;
    ksize_d     = ksize_q;
    nsize_d     = nsize_q;
    store_d     = store_q;
    overwrite_d = overwrite_q;
    if (accept) begin
      a_addr_d    = bus.desc_a_addr;
      b_addr_d    = bus.desc_b_addr;
      c_addr_d    = bus.desc_c_addr;
      a_stride_d  = bus.desc_a_stride;
      b_stride_d  = bus.desc_b_stride;
      msize_d     = bus.desc_msize;
      ksize_d     = bus.desc_ksize;
      nsize_d     = bus.desc_nsize;
      store_d     = bus.desc_store;
      overwrite_d = bus.desc_overwrite;
    end
  end

`ifdef GEMM_ISSUER_TIMEOUT_EN
  localparam int unsigned PCW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           poll_expired;

  // Counts POLL cycles already spent; zero on the first POLL cycle.
  assign poll_cnt_d   = (state_q == S_POLL) ? poll_cnt_q + PCW'(1) : '0;
  assign poll_expired = (poll_cnt_q == PCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) poll_cnt_q <= '0;
    else      poll_cnt_q <= poll_cnt_d;
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.desc_valid) state_d = S_POLL;
      S_POLL: begin
        if (!fifo_full) begin
          state_d = S_WR0;
        end
`ifdef GEMM_ISSUER_TIMEOUT_EN
        else if (poll_expired) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_WR0:   state_d = S_WR1;
      S_WR1:   state_d = S_WR2;
      S_WR2:   state_d = S_WR3;
      S_WR3:   state_d = S_WR4;
      S_WR4:   state_d = S_WR5;
      S_WR5:   state_d = S_WR6;
      S_WR6:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    en_d    = 1'b0;
    rdwr_d  = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    err_d   = timeout_hit;
    case (state_d)
      S_POLL: begin en_d = 1'b1; addr_d = BASE_ADDR; end
      S_WR0:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(0);  wdata_d = a_addr_q;   end
      S_WR1:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(4);  wdata_d = b_addr_q;   end
      S_WR2:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(8);  wdata_d = c_addr_q;   end
      S_WR3:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(12); wdata_d = a_stride_q; end
      S_WR4:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(16); wdata_d = b_stride_q; end
      S_WR5:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(20);
                    wdata_d = DW'({overwrite_q, store_q}); end
      // Dimension word goes last: its FIFO becoming non-empty marks the descriptor ready.
      S_WR6:  begin en_d = 1'b1; rdwr_d = 1'b1; addr_d = BASE_ADDR + AW'(24);
                    wdata_d = DW'({nsize_q, ksize_q, msize_q}); end
      default: ;
    endcase
  end

  assign issued_d = (state_q == S_WR6) ? issued_q + CW'(1) : issued_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      c_addr_q    <= '0;
      a_stride_q  <= '0;
      b_stride_q  <= '0;
      msize_q     <= '0;
      ksize_q     <= '0;
      nsize_q     <= '0;
      store_q     <= 1'b0;
      overwrite_q <= 1'b0;
      issued_q    <= '0;
      en_q        <= 1'b0;
      rdwr_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      c_addr_q    <= c_addr_d;
      a_stride_q  <= a_stride_d;
      b_stride_q  <= b_stride_d;
      msize_q     <= msize_d;
      ksize_q     <= ksize_d;
      nsize_q     <= nsize_d;
      store_q     <= store_d;
      overwrite_q <= overwrite_d;
      issued_q    <= issued_d;
      en_q        <= en_d;
      rdwr_q      <= rdwr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.desc_ready         = ready_q;
  assign bus.system_bus_en      = en_q;
  assign bus.system_bus_rdwr    = rdwr_q;
  assign bus.system_bus_addr    = addr_q;
  assign bus.system_bus_wr_data = wdata_q;
  assign busy                   = busy_q;
  assign issued_count           = issued_q;
  assign err_timeout            = err_q;
endmodule

// File: tb/tb_gemm_desc_issuer.sv
// Directed bench for gemm_desc_issuer: bus writes are scoreboarded against a queue
// filled when each descriptor is offered; the FIFO-full flag comes from a poll-count model.
module tb_gemm_desc_issuer;
  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int unsigned TMO  = 16;

  typedef struct packed {
    logic [31:0] a, b, c, sa, sb;
    logic [4:0]  m, k, n;
    logic        st, ow;
  } desc_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy;
  logic [15:0] issued_count;
  logic        err_timeout;
  logic        rd_full;

  int checks = 0, failures = 0;
  int cyc = 0, read_cnt = 0, write_cnt = 0, err_pulses = 0;
  int full_base = 0, full_target = 0;
  wr_t sb[$];

  gemm_desc_issuer_if bus_if ();

  gemm_desc_issuer #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .busy(busy), .issued_count(issued_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Full for the first full_target POLL reads of the current phase, then empty.
  assign rd_full = ((read_cnt - full_base) <= full_target);
  assign bus_if.system_bus_rd_data = {31'h1234_5678, rd_full};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge and check any bus transaction seen there.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (rst && bus_if.system_bus_en) begin
      if (bus_if.system_bus_rdwr) begin
        write_cnt++;
        chk("write_while_full", 32'((read_cnt - full_base) > full_target), 32'd1);
        chk("sb_entry_for_write", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", bus_if.system_bus_addr, e.addr);
          chk("wr_data", bus_if.system_bus_wr_data, e.data);
        end
      end else begin
        read_cnt++;
        chk("rd_addr", bus_if.system_bus_addr, BASE);
      end
    end
    if (rst && err_timeout) err_pulses++;
  endtask

  task automatic drive(input desc_t d);
    bus_if.desc_a_addr    = d.a;
    bus_if.desc_b_addr    = d.b;
    bus_if.desc_c_addr    = d.c;
    bus_if.desc_a_stride  = d.sa;
    bus_if.desc_b_stride  = d.sb;
    bus_if.desc_msize     = d.m;
    bus_if.desc_ksize     = d.k;
    bus_if.desc_nsize     = d.n;
    bus_if.desc_store     = d.st;
    bus_if.desc_overwrite = d.ow;
  endtask

  task automatic scramble();
    desc_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, 17'($urandom)};
    drive(r);
  endtask

  task automatic push_wr(input logic [31:0] off, input logic [31:0] data);
    wr_t e;
    e.addr = BASE + off;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_exp(input desc_t d);
    push_wr(32'd0,  d.a);
    push_wr(32'd4,  d.b);
    push_wr(32'd8,  d.c);
    push_wr(32'd12, d.sa);
    push_wr(32'd16, d.sb);
    push_wr(32'd20, {30'd0, d.ow, d.st});
    push_wr(32'd24, {17'd0, d.n, d.k, d.m});
  endtask

  // Wait (bounded) for ready, present d with valid high; accept happens at the next rising edge.
  task automatic offer(input desc_t d, input bit push, output int acc);
    int n = 0;
    while (bus_if.desc_ready !== 1'b1 && n < 60) begin tick(); n++; end
    chk("ready_before_offer", 32'(bus_if.desc_ready), 32'd1);
    drive(d);
    bus_if.desc_valid = 1'b1;
    if (push) push_exp(d);
    acc = cyc;
  endtask

  task automatic wait_ready(input int acc, input int lat, input bit keep, input bit scram,
                            input string tag);
    int n = 0;
    tick();
    if (!keep) bus_if.desc_valid = 1'b0;
    while (bus_if.desc_ready !== 1'b1 && n < 60) begin
      if (scram) scramble();
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(cyc - acc), 32'(lat));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(bus_if.desc_ready), 32'd1);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_en"},     32'(bus_if.system_bus_en), 32'd0);
    chk({tag, "_rdwr"},   32'(bus_if.system_bus_rdwr), 32'd0);
    chk({tag, "_addr"},   bus_if.system_bus_addr, 32'd0);
    chk({tag, "_wdata"},  bus_if.system_bus_wr_data, 32'd0);
    chk({tag, "_issued"}, 32'(issued_count), 32'd0);
    chk({tag, "_err"},    32'(err_timeout), 32'd0);
  endtask

  initial begin
    desc_t d1, d2, d4;
    desc_t bb[3];
    int acc, r0, w0, e0, n;

    bus_if.desc_valid = 1'b0;
    drive('0);
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) tick();

    // Single descriptor, FIFO not full; inputs scrambled after acceptance.
    d1 = '{a: 32'h1000, b: 32'h2000, c: 32'h3000, sa: 32'd64, sb: 32'd128,
           m: 5'd4, k: 5'd8, n: 5'd16, st: 1'b1, ow: 1'b0};
    full_target = 0; full_base = read_cnt; r0 = read_cnt; w0 = write_cnt;
    offer(d1, 1'b0, acc);
    push_wr(32'h00, 32'h1000); push_wr(32'h04, 32'h2000); push_wr(32'h08, 32'h3000);
    push_wr(32'h0C, 32'h40);   push_wr(32'h10, 32'h80);   push_wr(32'h14, 32'h1);
    push_wr(32'h18, 32'h4104);
    wait_ready(acc, 9, 1'b0, 1'b1, "t1");
    chk("t1_reads",  32'(read_cnt - r0), 32'd1);
    chk("t1_writes", 32'(write_cnt - w0), 32'd7);
    chk("t1_issued", 32'(issued_count), 32'd1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // FIFO full for five polls.
    d2 = '{a: 32'hA5A5_0000, b: 32'h0BAD_F00D, c: 32'hC0DE_0004, sa: 32'h100, sb: 32'h7F0,
           m: 5'd31, k: 5'd1, n: 5'd17, st: 1'b0, ow: 1'b1};
    full_target = 5; full_base = read_cnt; r0 = read_cnt; w0 = write_cnt;
    offer(d2, 1'b1, acc);
    wait_ready(acc, 14, 1'b0, 1'b1, "t2");
    chk("t2_reads",  32'(read_cnt - r0), 32'd6);
    chk("t2_writes", 32'(write_cnt - w0), 32'd7);
    chk("t2_issued", 32'(issued_count), 32'd2);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back: desc_valid stays high across three descriptors.
    full_target = 0; full_base = read_cnt;
    for (int i = 0; i < 3; i++) begin
      bb[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, 17'($urandom)};
      bb[i].a = 32'h5000 + 32'(i);
    end
    for (int i = 0; i < 3; i++) begin
      offer(bb[i], 1'b1, acc);
      wait_ready(acc, 9, 1'b1, 1'b0, "b2b");
    end
    bus_if.desc_valid = 1'b0;
    chk("b2b_issued", 32'(issued_count), 32'd5);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Reset asserted during the stride-A write.
    d4 = '{a: 32'h7000, b: 32'h7100, c: 32'h7200, sa: 32'h11, sb: 32'h22,
           m: 5'd2, k: 5'd3, n: 5'd5, st: 1'b1, ow: 1'b1};
    full_target = 0; full_base = read_cnt;
    offer(d4, 1'b1, acc);
    tick();
    bus_if.desc_valid = 1'b0;
    n = 0;
    while (!(bus_if.system_bus_en && bus_if.system_bus_rdwr &&
             bus_if.system_bus_addr == BASE + 32'd12) && n < 20) begin
      tick(); n++;
    end
    chk("t4_saw_wr3", 32'(n < 20), 32'd1);
    #1 rst = 1'b0;
    tick();
    chk_reset_outputs("t4_midrst");
    rst = 1'b1;
    sb.delete();
    w0 = write_cnt;
    repeat (12) tick();
    chk("t4_no_writes", 32'(write_cnt - w0), 32'd0);
    chk("t4_issued", 32'(issued_count), 32'd0);
    chk("t4_ready", 32'(bus_if.desc_ready), 32'd1);

`ifdef GEMM_ISSUER_TIMEOUT_EN
    // FIFO stays full: descriptor dropped after TMO polls.
    full_target = 100000; full_base = read_cnt; r0 = read_cnt; w0 = write_cnt; e0 = err_pulses;
    offer(d4, 1'b0, acc);
    wait_ready(acc, TMO + 1, 1'b0, 1'b0, "t5");
    repeat (4) tick();
    chk("t5_reads",  32'(read_cnt - r0), 32'(TMO));
    chk("t5_writes", 32'(write_cnt - w0), 32'd0);
    chk("t5_err_pulses", 32'(err_pulses - e0), 32'd1);
    chk("t5_issued", 32'(issued_count), 32'd0);
    full_target = 0; full_base = read_cnt;
    offer(d2, 1'b1, acc);
    wait_ready(acc, 9, 1'b0, 1'b0, "t5_recover");
    chk("t5_recover_issued", 32'(issued_count), 32'd1);
`else
    e0 = err_pulses;
`endif

    chk("final_err_pulses", 32'(err_pulses - e0), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gemm_desc_issuer.md
# gemm_desc_issuer

Bus initiator that issues GEMM tile descriptors into the accelerator's memory-mapped configuration register FIFOs at `BASE_ADDR`. It accepts one descriptor per valid/ready handshake from a command source, such as a host-side command queue or a test sequencer. Before writing, it polls the configuration FIFO full flag. It then performs seven single-cycle system-bus writes, with the tile-dimension word last, because the accelerator uses the emptiness of that FIFO as its "descriptor ready" indication.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h9000_0000: base address of the configuration register window.
- `TIMEOUT_CYCLES`, default 1024: maximum number of poll cycles. Used only when `GEMM_ISSUER_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `desc_valid`  input  1  descriptor offered.
- `desc_ready`  output  1  issuer can accept a descriptor; high only in IDLE.
- `desc_a_addr`, `desc_b_addr`, `desc_c_addr`  input  32 each  tile base addresses.
- `desc_a_stride`, `desc_b_stride`  input  32 each  tile strides.
- `desc_msize`, `desc_ksize`, `desc_nsize`  input  5 each  tile dimensions.
- `desc_store`, `desc_overwrite`  input  1 each  GEMM control bits.
- `system_bus_en`  output  1  bus transaction valid.
- `system_bus_rdwr`  output  1  1 = write, 0 = read.
- `system_bus_addr`  output  32  transaction address.
- `system_bus_wr_data`  output  32  write data.
- `system_bus_rd_data`  input  32  read data; combinational in the same cycle as the read request.
- `busy`  output  1  high in any state other than IDLE.
- `issued_count`  output  16  number of descriptors fully issued; wraps modulo 2^16.
- `err_timeout`  output  1  one-cycle pulse when a poll times out.

## Operation

- States: IDLE, POLL, WR0 to WR6.
- IDLE:
  - `desc_ready` = 1.
  - On `desc_valid` & `desc_ready`, latch all descriptor fields into internal registers and go to POLL.
- POLL:
  - Drive en=1, rdwr=0, addr=`BASE_ADDR`.
  - If `system_bus_rd_data[0]`=1 (FIFO full), stay in POLL.
  - If it is 0, go to WR0.
  - The offset-0 flag reflects the tile-A FIFO only. All seven target FIFOs are written as a group and popped together, so tile-A full implies the whole group is full.
- WRn: drive en=1, rdwr=1, advance one state per cycle. Address offsets and data:
  - WR0: offset 0, `a_addr`.
  - WR1: offset 4, `b_addr`.
  - WR2: offset 8, `c_addr`.
  - WR3: offset 12, `a_stride`.
  - WR4: offset 16, `b_stride`.
  - WR5: offset 20, {30'b0, overwrite, store}.
  - WR6: offset 24, {17'b0, nsize, ksize, msize}.
- WR6: `issued_count` increments on the clock edge that leaves WR6; next state is IDLE.
- Outputs in IDLE: en=0, rdwr=0, addr=0, wr_data=0.
- Bus outputs are decoded from the state and the latched registers. No write ever occurs outside WR0 to WR6.
- `desc_*` inputs are ignored when not in IDLE. Changing them after acceptance has no effect.
- Reset mid-operation:
  - Return immediately to IDLE and clear the latched descriptor, `issued_count` and `err_timeout`.
  - No resumption. Partially written target FIFOs are recovered only by the system-level reset of the target.

## Timing

- Reset values: `desc_ready`=1, `busy`=0, `system_bus_en`=0, `system_bus_rdwr`=0, `system_bus_addr`=0, `system_bus_wr_data`=0, `issued_count`=0, `err_timeout`=0.
- Accept edge T:
  - POLL read occurs in cycle T+1.
  - If not full, WR0 occurs in T+2 and WR6 (dimension write) in T+8.
  - `issued_count` updates at the end of T+8.
  - IDLE and `desc_ready`=1 return in T+9.
- Minimum issue interval is 9 cycles: one IDLE cycle, one POLL cycle, seven writes.
- Each cycle of full-flag polling adds one cycle to that descriptor's latency.
- Writes are fire-and-forget: the target captures each write at the edge ending the cycle. There is no wait-state input.

## Configuration

- `GEMM_ISSUER_TIMEOUT_EN` defined:
  - A poll counter clears on entering POLL and increments each POLL cycle.
  - When it reaches `TIMEOUT_CYCLES` while the FIFO is still full, the issuer drops the descriptor, pulses `err_timeout` for one cycle, and returns to IDLE.
  - No writes are issued for the dropped descriptor, and `issued_count` is unchanged.
- Not defined: POLL waits indefinitely, the counter logic is absent, and `err_timeout` is tied to 0.

## Test plan

- Reset release, then one descriptor (a_addr=0x1000, b_addr=0x2000, c_addr=0x3000, strides 64/128, m=4 k=8 n=16, store=1, overwrite=0), FIFO not full -> expected bus traffic:
  - One read at 0x9000_0000.
  - Seven writes at 0x9000_0000 to 0x9000_0018, with control=0x1 and dimension=0x4104.
  - `issued_count`=1, nine cycles from accept to ready.
- Hold `system_bus_rd_data[0]`=1 for 5 cycles, then 0 -> six POLL reads, then the seven writes; no write occurs while full.
- Keep `desc_valid` high continuously with 3 distinct descriptors -> accepted every 9 cycles in order; `issued_count`=3; `desc_ready` low throughout each issue.
- Assert `rst` low during WR3 -> next cycle all outputs are at reset values, `issued_count`=0, and no further writes occur.
- With `GEMM_ISSUER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, FIFO held full -> `err_timeout` pulses once after 16 POLL cycles, no writes occur, `issued_count` is unchanged, and the issuer returns to IDLE.
- Change `desc_*` inputs during WR1 to WR6 -> written data matches the values latched at acceptance.
